// File: rtl/pipe_pkg.sv
// Shared definitions for flow-controlled pipeline stages: default field
// widths, control-bit positions and the stage occupancy encoding.
package pipe_pkg;

  localparam int unsigned CTRL_W_DEF = 10;
  localparam int unsigned DATA_W_DEF = 133;
  localparam int unsigned CNT_W_DEF  = 16;

  // Bit positions inside the default control field.
  localparam int unsigned CTL_WREG     = 0;
  localparam int unsigned CTL_M2REG    = 1;
  localparam int unsigned CTL_WMEM     = 2;
  localparam int unsigned CTL_JAL      = 3;
  localparam int unsigned CTL_ALUIMM   = 4;
  localparam int unsigned CTL_SHIFT    = 5;
  localparam int unsigned CTL_ALUC_LSB = 6;

  // Occupancy, encoded as {skid_valid, main_valid}.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b01,
    ST_FULL  = 2'b11
  } stage_state_e;

endpackage

// File: rtl/pipe_slot.sv
// One storage slot of a pipeline stage: valid flag plus control and data
// fields. Clear drops only the valid flag; the payload keeps its value.
module pipe_slot
  import pipe_pkg::*;
#(
  parameter int unsigned CTRL_W = CTRL_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              load_i,
  input  logic              clear_i,
  input  logic [CTRL_W-1:0] ctrl_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              valid_o,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic [DATA_W-1:0] data_o
);

  logic              valid_q;
  logic [CTRL_W-1:0] ctrl_q;
  logic [DATA_W-1:0] data_q;

  // Slot register: clear wins over load, payload held when not loading.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
      data_q  <= '0;
    end else if (clear_i) begin
      valid_q <= 1'b0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      ctrl_q  <= ctrl_i;
      data_q  <= data_i;
    end
  end

  assign valid_o = valid_q;
  assign ctrl_o  = ctrl_q;
  assign data_o  = data_q;

endmodule

// File: rtl/pipe_stage_skid.sv
// Flow-controlled pipeline stage register with a 2-entry skid buffer,
// registered in_ready, synchronous flush and a saturating stall counter.
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int unsigned CTRL_W = CTRL_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned CNT_W  = CNT_W_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  stall_cnt
);

  logic              main_v, skid_v;
  logic [CTRL_W-1:0] main_ctrl, skid_ctrl;
  logic [DATA_W-1:0] main_data, skid_data;

  logic              main_load, main_from_skid, main_clear;
  logic              skid_load, skid_clear;
  logic [CTRL_W-1:0] main_ctrl_d;
  logic [DATA_W-1:0] main_data_d;

  logic              in_ready_q, in_ready_d;
  logic [CNT_W-1:0]  stall_q, stall_d;

  stage_state_e      state, state_d;
  logic              in_fire, out_fire;

  // The slot valid flags are the state register; state is read back from them.
  assign state    = stage_state_e'({skid_v, main_v});
  assign in_fire  = in_valid & in_ready_q;
  assign out_fire = main_v & out_ready;

  // Next-state logic; flush overrides every handshake.
  always_comb begin
    state_d = state;
    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state)
        ST_EMPTY: if (in_fire) state_d = ST_ONE;
        ST_ONE: begin
          if (in_fire && !out_fire)      state_d = ST_FULL;
          else if (!in_fire && out_fire) state_d = ST_EMPTY;
        end
        ST_FULL:  if (out_fire) state_d = ST_ONE;
        default:  state_d = ST_EMPTY;
      endcase
    end
  end

  // Slot control decode for each state/handshake combination.
  always_comb begin
    main_load      = 1'b0;
    main_from_skid = 1'b0;
    main_clear     = 1'b0;
    skid_load      = 1'b0;
    skid_clear     = 1'b0;
    if (flush) begin
      main_clear = 1'b1;
      skid_clear = 1'b1;
    end else begin
      case (state)
        ST_EMPTY: main_load = in_fire;
        ST_ONE: begin
          if (in_fire && out_fire)       main_load  = 1'b1;
          else if (in_fire)              skid_load  = 1'b1;
          else if (out_fire)             main_clear = 1'b1;
        end
        ST_FULL: begin
          if (out_fire) begin
            main_load      = 1'b1;
            main_from_skid = 1'b1;
            skid_clear     = 1'b1;
          end
        end
        default: begin
          main_clear = 1'b1;
          skid_clear = 1'b1;
        end
      endcase
    end
  end

  assign main_ctrl_d = main_from_skid ? skid_ctrl : in_ctrl;
  assign main_data_d = main_from_skid ? skid_data : in_data;

  pipe_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_main (
    .clk_i   (clock),
    .rst_i   (reset),
    .load_i  (main_load),
    .clear_i (main_clear),
    .ctrl_i  (main_ctrl_d),
    .data_i  (main_data_d),
    .valid_o (main_v),
    .ctrl_o  (main_ctrl),
    .data_o  (main_data)
  );

  pipe_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_skid (
    .clk_i   (clock),
    .rst_i   (reset),
    .load_i  (skid_load),
    .clear_i (skid_clear),
    .ctrl_i  (in_ctrl),
    .data_i  (in_data),
    .valid_o (skid_v),
    .ctrl_o  (skid_ctrl),
    .data_o  (skid_data)
  );

  assign in_ready_d = (state_d != ST_FULL);
  assign stall_d    = (main_v && !out_ready && (stall_q != '1))
                      ? stall_q + CNT_W'(1) : stall_q;

  // Registered ready and stall counter; the counter ignores flush.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      in_ready_q <= 1'b1;
      stall_q    <= '0;
    end else begin
      in_ready_q <= in_ready_d;
      stall_q    <= stall_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = main_v;
  assign out_ctrl  = main_ctrl & {CTRL_W{main_v}};
  assign out_data  = main_data;
  assign stall_cnt = stall_q;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed bench for pipe_stage_skid (4-bit stall counter to reach saturation).
module tb_pipe_stage_skid;

  localparam int unsigned CW = 10;
  localparam int unsigned DW = 133;
  localparam int unsigned NW = 4;

  logic          clock = 1'b0;
  logic          reset, flush, in_valid, out_ready;
  logic          in_ready, out_valid;
  logic [CW-1:0] in_ctrl, out_ctrl;
  logic [DW-1:0] in_data, out_data;
  logic [NW-1:0] stall_cnt;

  int checks   = 0;
  int failures = 0;

  pipe_stage_skid #(.CTRL_W(CW), .DATA_W(DW), .CNT_W(NW)) dut (
    .clock     (clock),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_ctrl   (in_ctrl),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ctrl  (out_ctrl),
    .out_data  (out_data),
    .stall_cnt (stall_cnt)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [139:0] obs, input logic [139:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic v, input logic [CW-1:0] c, input logic [DW-1:0] d);
    in_valid = v;
    in_ctrl  = c;
    in_data  = d;
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; out_ready = 1'b0;
    drive(1'b0, '0, '0);
    #3;
    chk("rst_out_valid", 140'(out_valid), 140'(0));
    chk("rst_in_ready",  140'(in_ready),  140'(1));
    chk("rst_stall",     140'(stall_cnt), 140'(0));
    chk("rst_out_data",  140'(out_data),  140'(0));
    tick();
    reset = 1'b0;

    // Streaming 1..4 with downstream always ready
    out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, 10'h001, DW'(i));
      tick();
      chk("stream_valid", 140'(out_valid), 140'(1));
      chk("stream_data",  140'(out_data),  140'(i));
      chk("stream_ready", 140'(in_ready),  140'(1));
    end
    drive(1'b0, '0, '0);
    tick();
    chk("drain_valid", 140'(out_valid), 140'(0));
    chk("drain_ctrl",  140'(out_ctrl),  140'(0));
    chk("drain_data",  140'(out_data),  140'(4));
    chk("drain_stall", 140'(stall_cnt), 140'(0));

    // Skid fill: A then B while stalled, C offered but blocked
    out_ready = 1'b0;
    drive(1'b1, 10'h00A, DW'(16'hAAAA));
    tick();
    chk("skidA_data",  140'(out_data),  140'(16'hAAAA));
    chk("skidA_ready", 140'(in_ready),  140'(1));
    chk("skidA_stall", 140'(stall_cnt), 140'(0));
    drive(1'b1, 10'h00B, DW'(16'hBBBB));
    tick();
    chk("full_ready", 140'(in_ready),  140'(0));
    chk("full_data",  140'(out_data),  140'(16'hAAAA));
    chk("full_stall", 140'(stall_cnt), 140'(1));
    drive(1'b1, 10'h00C, DW'(16'hCCCC));
    tick();
    chk("hold_ready", 140'(in_ready),  140'(0));
    chk("hold_stall", 140'(stall_cnt), 140'(2));
    out_ready = 1'b1;
    drive(1'b0, '0, '0);
    tick();
    chk("popA_data",  140'(out_data),  140'(16'hBBBB));
    chk("popA_ctrl",  140'(out_ctrl),  140'(10'h00B));
    chk("popA_ready", 140'(in_ready),  140'(1));
    chk("popA_stall", 140'(stall_cnt), 140'(2));
    tick();
    chk("popB_valid", 140'(out_valid), 140'(0));
    chk("popB_data",  140'(out_data),  140'(16'hBBBB));

    // Flush while FULL with C offered
    out_ready = 1'b0;
    drive(1'b1, 10'h2A5, DW'(16'h0011));
    tick();
    drive(1'b1, 10'h0F0, DW'(16'h0022));
    tick();
    chk("pref_ready", 140'(in_ready),  140'(0));
    chk("pref_ctrl",  140'(out_ctrl),  140'(10'h2A5));
    chk("pref_stall", 140'(stall_cnt), 140'(3));
    flush = 1'b1;
    drive(1'b1, 10'h155, DW'(16'h00CC));
    tick();
    flush = 1'b0;
    chk("flF_valid", 140'(out_valid), 140'(0));
    chk("flF_ctrl",  140'(out_ctrl),  140'(0));
    chk("flF_data",  140'(out_data),  140'(16'h0011));
    chk("flF_ready", 140'(in_ready),  140'(1));
    chk("flF_stall", 140'(stall_cnt), 140'(4));
    drive(1'b0, '0, '0);
    out_ready = 1'b1;
    tick();
    chk("flF_noC", 140'(out_valid), 140'(0));

    // Flush while ONE with an accepted push that must be dropped
    out_ready = 1'b0;
    drive(1'b1, 10'h2A5, DW'(16'h0D0D));
    tick();
    chk("one_ctrl",  140'(out_ctrl),  140'(10'h2A5));
    chk("one_stall", 140'(stall_cnt), 140'(4));
    flush = 1'b1;
    drive(1'b1, 10'h3C3, DW'(16'h0E0E));
    tick();
    flush = 1'b0;
    drive(1'b0, '0, '0);
    chk("fl1_valid", 140'(out_valid), 140'(0));
    chk("fl1_ctrl",  140'(out_ctrl),  140'(0));
    chk("fl1_data",  140'(out_data),  140'(16'h0D0D));
    chk("fl1_ready", 140'(in_ready),  140'(1));
    chk("fl1_stall", 140'(stall_cnt), 140'(5));
    tick();
    chk("fl1_noE", 140'(out_valid), 140'(0));

    // Stall counter saturation, unaffected by flush
    drive(1'b1, 10'h001, DW'(16'h0F0F));
    tick();
    drive(1'b0, '0, '0);
    for (int i = 0; i < 20; i++) tick();
    chk("sat_stall", 140'(stall_cnt), 140'(15));
    chk("sat_valid", 140'(out_valid), 140'(1));
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("sat_fl_stall", 140'(stall_cnt), 140'(15));
    chk("sat_fl_valid", 140'(out_valid), 140'(0));

    // Asynchronous reset while FULL
    drive(1'b1, 10'h3FF, DW'(16'h1111));
    tick();
    drive(1'b1, 10'h001, DW'(16'h2222));
    tick();
    chk("prer_ready", 140'(in_ready), 140'(0));
    chk("prer_ctrl",  140'(out_ctrl), 140'(10'h3FF));
    reset = 1'b1;
    #1;
    chk("ar_valid", 140'(out_valid), 140'(0));
    chk("ar_ctrl",  140'(out_ctrl),  140'(0));
    chk("ar_data",  140'(out_data),  140'(0));
    chk("ar_ready", 140'(in_ready),  140'(1));
    chk("ar_stall", 140'(stall_cnt), 140'(0));
    out_ready = 1'b1;
    drive(1'b1, 10'h004, DW'(16'h3333));
    tick();
    chk("ar_ignore", 140'(out_valid), 140'(0));
    reset = 1'b0;
    tick();
    chk("post_valid", 140'(out_valid), 140'(1));
    chk("post_data",  140'(out_data),  140'(16'h3333));
    chk("post_ctrl",  140'(out_ctrl),  140'(10'h004));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipe_stage_skid.md
Name: pipe_stage_skid

Overview:
- Parametrised, flow-controlled pipeline stage register. Successor to the fixed-width, always-enabled inter-stage registers in the CPU datapath (ID/EX, EX/MEM, MEM/WB).
- Adds valid/ready handshaking and a 2-entry skid buffer, so upstream `in_ready` is registered and never combinationally depends on `out_ready`.
- Adds a synchronous flush that inserts a bubble, and a saturating stall counter.
- Sits between any two pipeline stages; control and data fields travel as separate buses.

Parameters:
- CTRL_W, 10, control field width (default: wreg, m2reg, wmem, jal, aluimm, shift, aluc[3:0]).
- DATA_W, 133, data field width (default: pc4, a, b, imm at 32b each, plus rn at 5b).
- CNT_W, 16, stall counter width.

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- flush  in  1  synchronous bubble insert / stage kill
- in_valid  in  1  upstream holds a valid item
- in_ready  out  1  stage can accept; registered
- in_ctrl  in  CTRL_W  upstream control bits
- in_data  in  DATA_W  upstream data
- out_valid  out  1  stage holds a valid item
- out_ready  in  1  downstream accepts
- out_ctrl  out  CTRL_W  control bits; forced 0 when out_valid=0
- out_data  out  DATA_W  data of the head entry
- stall_cnt  out  CNT_W  saturating count of back-pressured cycles

Behaviour:
- Interface: one clock; reset is asynchronous and active-high.
- Storage:
  - main slot drives the outputs.
  - skid slot catches one item accepted while downstream stalls.
- Transfers:
  - in_fire = in_valid & in_ready
  - out_fire = out_valid & out_ready
- States, derived from slot valids:
  - EMPTY: main invalid, skid invalid.
  - ONE: main valid, skid invalid.
  - FULL: main valid, skid valid.
- Transitions, applied when flush=0:
  - EMPTY: in_fire -> ONE, main <= in. Otherwise stay EMPTY.
  - ONE, in_fire & out_fire -> ONE, main <= in.
  - ONE, in_fire & !out_fire -> FULL, skid <= in.
  - ONE, !in_fire & out_fire -> EMPTY.
  - ONE, neither -> hold.
  - FULL: out_fire -> ONE, main <= skid. Otherwise hold. in_fire cannot occur because in_ready=0.
- Ordering: strict FIFO order is preserved. The skid entry always leaves after the main entry.
- in_ready: registered; next value is 1 iff next state != FULL.
- Latency: 1 cycle from in_fire to out_valid when EMPTY. Throughput is 1 item/cycle while out_ready=1.
- Flush: highest priority.
  - Next state is EMPTY and both valids clear.
  - Any in_fire in the same cycle is discarded.
  - in_ready is 1 the following cycle.
  - The out_fire occurring in the flush cycle still completes; downstream is responsible for its own kill.
- Bubble: out_ctrl = main_ctrl AND out_valid, so a bubble never writes registers or memory. out_data holds its last value when invalid; data is don't-care but deterministic.
- Stall counter: increments when out_valid & !out_ready, saturates at all-ones, and is unaffected by flush.
- Reset (asynchronous, takes effect immediately, including mid-transfer):
  - state EMPTY; all slot ctrl/data = 0.
  - out_valid = 0, out_ctrl = 0, out_data = 0.
  - in_ready = 1, stall_cnt = 0.
  - Handshakes are ignored while reset is high.
- The stage holds no combinational path from in_* to out_* or from out_ready to in_ready.

Decomposition:
- Shared package pipe_pkg:
  - default CTRL_W/DATA_W constants.
  - control bit index constants: CTL_WREG=0, CTL_M2REG=1, CTL_WMEM=2, CTL_JAL=3, CTL_ALUIMM=4, CTL_SHIFT=5, CTL_ALUC_LSB=6.
  - state encoding: EMPTY=2'b00, ONE=2'b01, FULL=2'b11.
- Sub-module pipe_slot: valid + ctrl + data register with load and clear inputs and async reset. Instantiated twice (main and skid).

Test Plan:
- Reset mid-stream: assert reset while FULL with main ctrl=10'h3FF -> out_valid=0, out_ctrl=0, in_ready=1, stall_cnt=0 immediately; accepts items 1 cycle after release.
- Streaming: out_ready=1, in_valid=1 with data 1,2,3,4 on consecutive cycles -> out_data 1,2,3,4 on the next 4 cycles, 1 cycle latency, in_ready stays 1.
- Skid fill: push A, B while out_ready=0 -> state FULL, in_ready=0 next cycle, stall_cnt counts; raise out_ready -> A then B, in_ready=1 the cycle after A leaves.
- Flush with simultaneous push: FULL with items A, B, flush=1 and in_valid=1 with item C -> next cycle out_valid=0, out_ctrl=0, C never appears, in_ready=1.
- Bubble control gating: flush a stage holding ctrl=10'h2A5 -> out_ctrl=0 while out_valid=0; out_data unchanged.
- Counter saturation: CNT_W=4, hold out_valid=1 and out_ready=0 for 20 cycles -> stall_cnt stops at 4'hF; a flush does not clear it.
